// File: rtl/controlador_memoria_if.sv
// Request, response and memory-side signals of the memory request sequencer.
// The slave view belongs to the sequencer; the master view belongs to its environment.
interface controlador_memoria_if #(
   parameter int ANCHO_DIR  = 5,
   parameter int ANCHO_DATO = 32
);
   logic                  sol_valido;
   logic                  sol_listo;
   logic                  sol_escribe;
   logic [ANCHO_DIR-1:0]  sol_dir;
   logic [ANCHO_DATO-1:0] sol_dato;
   logic [ANCHO_DIR-1:0]  Direccion;
   logic [ANCHO_DATO-1:0] Dato;
   logic                  WE;
   logic [ANCHO_DATO-1:0] Q4;
   logic                  resp_valido;
   logic [ANCHO_DATO-1:0] resp_dato;
   logic [ANCHO_DIR-1:0]  resp_dir;
   logic                  resp_listo;
   logic                  ocupado;

   modport slave (
      input  sol_valido, sol_escribe, sol_dir, sol_dato, Q4, resp_listo,
      output sol_listo, Direccion, Dato, WE, resp_valido, resp_dato, resp_dir, ocupado
   );

   modport master (
      output sol_valido, sol_escribe, sol_dir, sol_dato, Q4, resp_listo,
      input  sol_listo, Direccion, Dato, WE, resp_valido, resp_dato, resp_dir, ocupado
   );
endinterface

// File: rtl/controlador_memoria.sv
// In-order request sequencer in front of the 32x32 register memory: queues read/write
// requests, issues one per cycle to the memory and returns read data over valid/ready.
module controlador_memoria #(
   parameter int PROF       = 4,
   parameter int ANCHO_DIR  = 5,
   parameter int ANCHO_DATO = 32
) (
   input logic                 clk,
   input logic                 rst,
   controlador_memoria_if.slave bus
);
   localparam int AP = (PROF > 1) ? $clog2(PROF) : 1;

   typedef struct packed {
      logic                  escribe;
      logic [ANCHO_DIR-1:0]  dir;
      logic [ANCHO_DATO-1:0] dato;
   } entrada_t;

   typedef enum logic [1:0] {INACTIVO, EMITIR, RESPUESTA} estado_t;

   estado_t               estado;
   entrada_t              fifo [PROF];
   entrada_t              cabeza;
   logic [AP-1:0]         pw, pr;
   logic [AP:0]           count, count_sig;
   logic                  lleno, push, pop;
   logic [ANCHO_DIR-1:0]  dir_q;
   logic                  resp_valido_q;
   logic [ANCHO_DATO-1:0] resp_dato_q;
   logic [ANCHO_DIR-1:0]  resp_dir_q;

   assign cabeza    = fifo[pr];
   assign lleno     = (count == (AP+1)'(PROF));
   assign push      = bus.sol_valido && !lleno;
   assign pop       = (estado == EMITIR);
   assign count_sig = count + (AP+1)'(push) - (AP+1)'(pop);

   assign bus.sol_listo   = !lleno;
   // Outside EMITIR the address bus keeps the last issued address.
   assign bus.Direccion   = (estado == EMITIR) ? cabeza.dir : dir_q;
   assign bus.Dato        = (estado == EMITIR && cabeza.escribe) ? cabeza.dato : '0;
   assign bus.WE          = (estado == EMITIR) && cabeza.escribe && !rst;
   assign bus.ocupado     = (estado != INACTIVO) || (count != '0);
   assign bus.resp_valido = resp_valido_q;
   assign bus.resp_dato   = resp_dato_q;
   assign bus.resp_dir    = resp_dir_q;

   always_ff @(posedge clk) begin
      if (push) fifo[pw] <= '{escribe: bus.sol_escribe, dir: bus.sol_dir, dato: bus.sol_dato};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado        <= INACTIVO;
         pw            <= '0;
         pr            <= '0;
         count         <= '0;
         dir_q         <= '0;
         resp_valido_q <= 1'b0;
         resp_dato_q   <= '0;
         resp_dir_q    <= '0;
      end else begin
         count <= count_sig;
         if (push) pw <= pw + AP'(1);
         if (pop)  pr <= pr + AP'(1);
         case (estado)
            INACTIVO:
               if (count_sig != '0) estado <= EMITIR;
            EMITIR: begin
               dir_q <= cabeza.dir;
               if (cabeza.escribe) begin
                  estado <= (count_sig != '0) ? EMITIR : INACTIVO;
               end else begin
                  resp_dato_q   <= bus.Q4;
                  resp_dir_q    <= cabeza.dir;
                  resp_valido_q <= 1'b1;
                  estado        <= RESPUESTA;
               end
            end
            RESPUESTA:
               // Requests keep queueing here; the response is held until taken.
               if (bus.resp_listo) begin
                  resp_valido_q <= 1'b0;
                  estado        <= (count_sig != '0) ? EMITIR : INACTIVO;
               end
            default:
               estado <= INACTIVO;
         endcase
      end
   end
endmodule
